seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Runtime-programmable serial pattern detector. It generalises the fixed 010101 Moore/Mealy detectors to any pattern up to MAX_LEN bits, with selectable overlap or non-overlap mode, a bit-valid qualifier and a saturating match counter. It provides both a Mealy (same-cycle) and a Moore (registered) match output. It sits after a serial-bit source (deserialiser or UART RX), and downstream control logic consumes its match pulse and count.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (2..32).
CNT_W, 8, width of the saturating match counter.
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived, not overridden).

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
a  in  1  serial input bit
a_valid  in  1  a is sampled only on cycles where this is 1
cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap
cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first-received bit, bit 0 is the last
cfg_len  in  LEN_W  pattern length; legal range is 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = restart after each match
clr_count  in  1  synchronous clear of match_count
y_mealy  out  1  combinational: this cycle's valid bit completes a match
y  out  1  registered: one-cycle pulse in the cycle after the completing bit
match_count  out  CNT_W  number of matches, saturating
cfg_err  out  1  last cfg_load carried an illegal cfg_len
armed  out  1  detector in ARMED state (history holds at least len bits)

Behaviour:
- Reset (reset_n low, async): state IDLE; history, fill, pattern, len and overlap all 0. Outputs y=0, match_count=0, cfg_err=0, armed=0. y_mealy=0 because the state is IDLE.
- States: IDLE (no valid configuration), FILL (fill < len), ARMED (fill >= len).
- cfg_load: registers the config, clears history and fill, and clears match_count.
  - cfg_len in 1..MAX_LEN: next state FILL, cfg_err=0.
  - Otherwise: next state IDLE, cfg_err=1.
  - cfg_load takes priority over a_valid in the same cycle; that bit is discarded.
- Per valid bit (a_valid=1, not IDLE, no cfg_load):
  - hist_next = {hist[MAX_LEN-2:0], a}
  - fill_next = min(fill+1, MAX_LEN)
  - hit = (fill_next >= len) && (((hist_next ^ pattern) & mask(len)) == 0), where mask(len) = low len bits set.
- y_mealy = hit, combinational on a, a_valid and state. It is 0 in IDLE and on non-valid cycles.
- y <= hit on every clock, so y is a single-cycle pulse with latency 1.
- On a hit:
  - Overlap mode: fill_next stands; state stays ARMED.
  - Non-overlap mode: fill is forced to 0 and state goes to FILL. The history is not cleared, but it is masked by fill.
- Transitions: FILL -> ARMED when fill_next >= len and the bit is not a non-overlap hit. ARMED persists otherwise. With len=1 in non-overlap mode the state returns to FILL every hit, and every matching bit still hits.
- Non-valid cycles: no state change; y falls to 0.
- match_count increments on hit and saturates at 2^CNT_W-1. Priority: clr_count beats hit, so a same-cycle clear and hit yield 0.
- Reset mid-pattern: partial history is lost and detection restarts from IDLE. Configuration must be reloaded.
- armed = (state == ARMED).

Decomposition:
- Package seq_det_pkg holds:
  - typedef enum logic [1:0] {IDLE, FILL, ARMED} det_state_t
  - function len_mask(len), returning a MAX_LEN-bit mask
- Sub-module sat_counter (parameter W; inputs inc and clr with clr priority; output cnt) implements the match counter.
- History register, compare logic and FSM stay in the top module.

Test Plan:
- Overlap detection: cfg_pattern=6'b010101, len=6, overlap=1; stream 010101010101 with a_valid=1 throughout -> y_mealy on bits 6, 8, 10 and 12; y the cycle after each; match_count=4.
- Non-overlap detection: same stream, overlap=0 -> hits on bits 6 and 12 only; match_count=2.
- Valid gaps: same overlap stream with a_valid low for 3 cycles between each bit -> identical hit sequence; y asserted only one cycle after each completing valid bit.
- Illegal configuration: cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err=1, state IDLE, y stays 0 over any stream. A following legal load (len=3, pattern 3'b111) with stream 1111 -> cfg_err=0; hits on bits 3 and 4 (overlap).
- Counter saturation and clear: CNT_W=2, pattern 1'b1, len=1, stream of five 1s -> match_count goes 1, 2, 3, 3, 3. clr_count asserted together with a hit -> match_count=0.
- Reset mid-pattern: load 010101 and feed 0101; pulse reset_n low async between clock edges -> all outputs 0 immediately. Reload and feed 01 -> no hit (history cleared); continuing with 0101 then gives a hit on the 6th post-reload bit.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ARMED = 2'd2
  } det_state_t;

  // Widest pattern the detector can be built for; masks are produced at this width and
  // callers compare a zero-extended difference against them.
  localparam int unsigned MaskW = 32;

  // Low len bits set; len >= 32 yields all ones.
  function automatic logic [MaskW-1:0] len_mask(input logic [5:0] len);
    logic [MaskW-1:0] m;
    if (len >= 6'd32) begin
      m = '1;
    end else begin
      m = (MaskW'(1) << len) - MaskW'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Bit stream, configuration and result signals of the pattern detector.
interface seq_detector_param_if #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               a;
  logic               a_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               clr_count;
  logic               y_mealy;
  logic               y;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;
  logic               armed;

  modport master (
    output a, a_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    input  y_mealy, y, match_count, cfg_err, armed
  );

  modport slave (
    input  a, a_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
    output y_mealy, y, match_count, cfg_err, armed
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear wins over a same-cycle increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else increment unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control, Mealy and Moore
// match outputs and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  seq_detector_param_if.slave det_if
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);

  det_state_t         state_q, state_d;
  logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d, hist_next;
  logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d, fill_inc;
  logic               ovl_q, ovl_d;
  logic               cfg_err_q, cfg_err_d;
  logic               y_q;
  logic               bit_ok, hit, cfg_legal;
  logic [CNT_W-1:0]   cnt;

  // Match decision for the bit presented this cycle.
  always_comb begin
    bit_ok    = det_if.a_valid && (state_q != IDLE) && !det_if.cfg_load;
    hist_next = (hist_q << 1) | MAX_LEN'(det_if.a);
    fill_inc  = (fill_q == MaxLenW) ? fill_q : fill_q + LEN_W'(1);
    hit       = bit_ok && (fill_inc >= len_q) &&
                ((MaskW'(hist_next ^ pat_q) & len_mask(6'(len_q))) == '0);
    cfg_legal = (det_if.cfg_len != '0) && (det_if.cfg_len <= MaxLenW);
  end

  // Next state: configuration load first, then valid-bit consumption.
  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    pat_d     = pat_q;
    len_d     = len_q;
    ovl_d     = ovl_q;
    cfg_err_d = cfg_err_q;
    if (det_if.cfg_load) begin
      pat_d     = det_if.cfg_pattern;
      len_d     = det_if.cfg_len;
      ovl_d     = det_if.cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      cfg_err_d = !cfg_legal;
      state_d   = cfg_legal ? FILL : IDLE;
    end else if (bit_ok) begin
      hist_d = hist_next;
      if (hit && !ovl_q) begin
        // Restart: stale history is ignored because fill gates the compare.
        fill_d  = '0;
        state_d = FILL;
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc >= len_q) ? ARMED : FILL;
      end
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      hist_q    <= '0;
      fill_q    <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      cfg_err_q <= 1'b0;
      y_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      ovl_q     <= ovl_d;
      cfg_err_q <= cfg_err_d;
      y_q       <= hit;
    end
  end

  // A new configuration also clears the count.
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .inc_i  (hit),
    .clr_i  (det_if.clr_count | det_if.cfg_load),
    .cnt_o  (cnt)
  );

  assign det_if.y_mealy     = hit;
  assign det_if.y           = y_q;
  assign det_if.match_count = cnt;
  assign det_if.cfg_err     = cfg_err_q;
  assign det_if.armed       = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: a default-width detector plus a 2-bit-counter copy fed the same inputs.
module tb_seq_detector_param;

  localparam int unsigned MaxLen = 16;
  localparam int unsigned LenW   = 5;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  seq_detector_param_if #(.MAX_LEN(MaxLen), .CNT_W(8)) if_m ();
  seq_detector_param_if #(.MAX_LEN(MaxLen), .CNT_W(2)) if_s ();

  assign if_s.a           = if_m.a;
  assign if_s.a_valid     = if_m.a_valid;
  assign if_s.cfg_load    = if_m.cfg_load;
  assign if_s.cfg_pattern = if_m.cfg_pattern;
  assign if_s.cfg_len     = if_m.cfg_len;
  assign if_s.cfg_overlap = if_m.cfg_overlap;
  assign if_s.clr_count   = if_m.clr_count;

  seq_detector_param #(.MAX_LEN(MaxLen), .CNT_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .det_if  (if_m)
  );

  seq_detector_param #(.MAX_LEN(MaxLen), .CNT_W(2)) dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .det_if  (if_s)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: Mealy output checked mid-cycle, registered output just after the edge.
  task automatic bit_step(input logic b, input logic v, input logic exp_m, input string tag);
    if_m.a       = b;
    if_m.a_valid = v;
    @(negedge clk);
    check(32'(if_m.y_mealy), 32'(exp_m), {tag, "_mealy"});
    @(posedge clk);
    #1;
    check(32'(if_m.y), 32'(exp_m), {tag, "_y"});
    if_m.a_valid = 1'b0;
  endtask

  // bits[i] is the (i+1)th received bit; exp[i] says whether it completes a match.
  task automatic run_stream(input logic [11:0] bits, input logic [11:0] exp, input int n,
                            input int gaps, input string tag);
    for (int i = 0; i < n; i++) begin
      bit_step(bits[i], 1'b1, exp[i], $sformatf("%s_b%0d", tag, i + 1));
      for (int g = 0; g < gaps; g++) begin
        bit_step(1'($urandom_range(1, 0)), 1'b0, 1'b0, $sformatf("%s_gap%0d_%0d", tag, i + 1, g));
      end
    end
  endtask

  // Load with a valid bit present in the same cycle; that bit must be discarded.
  task automatic load(input logic [MaxLen-1:0] pat, input logic [LenW-1:0] len, input logic ovl,
                      input logic exp_err, input string tag);
    if_m.cfg_pattern = pat;
    if_m.cfg_len     = len;
    if_m.cfg_overlap = ovl;
    if_m.cfg_load    = 1'b1;
    if_m.a           = 1'b1;
    if_m.a_valid     = 1'b1;
    @(negedge clk);
    check(32'(if_m.y_mealy), 32'd0, {tag, "_load_mealy"});
    @(posedge clk);
    #1;
    if_m.cfg_load = 1'b0;
    if_m.a_valid  = 1'b0;
    check(32'(if_m.cfg_err), 32'(exp_err), {tag, "_cfg_err"});
    check(32'(if_m.armed), 32'd0, {tag, "_armed"});
    check(32'(if_m.match_count), 32'd0, {tag, "_cnt"});
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    reset_n          = 1'b0;
    if_m.a           = 1'b0;
    if_m.a_valid     = 1'b0;
    if_m.cfg_load    = 1'b0;
    if_m.cfg_pattern = '0;
    if_m.cfg_len     = '0;
    if_m.cfg_overlap = 1'b0;
    if_m.clr_count   = 1'b0;

    // Reset state, including Mealy output held low in IDLE with a valid bit present.
    #12;
    if_m.a       = 1'b1;
    if_m.a_valid = 1'b1;
    #1;
    check(32'(if_m.y), 32'd0, "rst_y");
    check(32'(if_m.y_mealy), 32'd0, "rst_mealy");
    check(32'(if_m.match_count), 32'd0, "rst_cnt");
    check(32'(if_m.cfg_err), 32'd0, "rst_cfg_err");
    check(32'(if_m.armed), 32'd0, "rst_armed");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    bit_step(1'b1, 1'b1, 1'b0, "idle_bit");

    // Overlap detection of 010101.
    load(16'b010101, 5'd6, 1'b1, 1'b0, "ovl");
    run_stream(12'b1010_1010_1010, 12'b1010_1010_0000, 12, 0, "ovl");
    check(32'(if_m.match_count), 32'd4, "ovl_cnt");
    check(32'(if_m.armed), 32'd1, "ovl_armed");

    // Non-overlap: restart after each match.
    load(16'b010101, 5'd6, 1'b0, 1'b0, "novl");
    run_stream(12'b1010_1010_1010, 12'b1000_0010_0000, 12, 0, "novl");
    check(32'(if_m.match_count), 32'd2, "novl_cnt");
    check(32'(if_m.armed), 32'd0, "novl_armed");

    // Overlap with three invalid cycles after each bit.
    load(16'b010101, 5'd6, 1'b1, 1'b0, "gap");
    run_stream(12'b1010_1010_1010, 12'b1010_1010_0000, 12, 3, "gap");
    check(32'(if_m.match_count), 32'd4, "gap_cnt");

    // Illegal lengths leave the detector idle.
    load(16'h0001, 5'd0, 1'b1, 1'b1, "ill0");
    run_stream(12'h00F, 12'h000, 4, 0, "ill0");
    load(16'h0001, 5'd17, 1'b1, 1'b1, "ill17");
    run_stream(12'h00F, 12'h000, 4, 0, "ill17");
    check(32'(if_m.match_count), 32'd0, "ill_cnt");
    load(16'b111, 5'd3, 1'b1, 1'b0, "leg3");
    run_stream(12'h00F, 12'b1100, 4, 0, "leg3");
    check(32'(if_m.match_count), 32'd2, "leg3_cnt");

    // Saturation on the 2-bit counter copy, then clear against a hit.
    load(16'b1, 5'd1, 1'b1, 1'b0, "sat");
    for (int i = 0; i < 5; i++) begin
      bit_step(1'b1, 1'b1, 1'b1, $sformatf("sat_b%0d", i + 1));
      check(32'(if_s.match_count), 32'(sat_exp[i]), $sformatf("sat_cnt%0d", i + 1));
    end
    check(32'(if_m.match_count), 32'd5, "sat_wide_cnt");
    if_m.clr_count = 1'b1;
    bit_step(1'b1, 1'b1, 1'b1, "clr_hit");
    if_m.clr_count = 1'b0;
    check(32'(if_s.match_count), 32'd0, "clr_sat_cnt");
    check(32'(if_m.match_count), 32'd0, "clr_wide_cnt");
    bit_step(1'b1, 1'b1, 1'b1, "post_clr");
    check(32'(if_m.match_count), 32'd1, "post_clr_cnt");

    // len=1 non-overlap: every matching bit hits.
    load(16'b1, 5'd1, 1'b0, 1'b0, "n1");
    run_stream(12'b101, 12'b101, 3, 0, "n1");
    check(32'(if_m.match_count), 32'd2, "n1_cnt");

    // Asynchronous reset mid-pattern, just after a completing bit so y is high.
    load(16'b010101, 5'd6, 1'b1, 1'b0, "mid");
    run_stream(12'b1010_1010, 12'b1010_0000, 8, 0, "mid");
    #2;
    reset_n      = 1'b0;
    if_m.a       = 1'b1;
    if_m.a_valid = 1'b1;
    #1;
    check(32'(if_m.y), 32'd0, "arst_y");
    check(32'(if_m.y_mealy), 32'd0, "arst_mealy");
    check(32'(if_m.match_count), 32'd0, "arst_cnt");
    check(32'(if_m.armed), 32'd0, "arst_armed");
    check(32'(if_m.cfg_err), 32'd0, "arst_cfg_err");
    #1;
    reset_n      = 1'b1;
    if_m.a_valid = 1'b0;
    @(posedge clk);
    #1;
    load(16'b010101, 5'd6, 1'b1, 1'b0, "rl");
    run_stream(12'b10_1010, 12'b10_0000, 6, 0, "rl");
    check(32'(if_m.match_count), 32'd1, "rl_cnt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
